alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared combinational ALU
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention.
module alu_arbiter #(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_f,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_f,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic [2:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_f
);

  // Opcode driven onto the idle ALU; the arbiter never interprets opcodes otherwise.
  localparam logic [2:0] ALU_ADD = 3'd0;

  // last_gnt_q = 1 means requester 1 won most recently, so requester 0 wins the next tie.
  logic             last_gnt_q, last_gnt_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [31:0]      rsp0_f_q, rsp0_f_d;
  logic [31:0]      rsp1_f_q, rsp1_f_d;
  logic [TAG_W-1:0] rsp0_tag_q, rsp0_tag_d;
  logic [TAG_W-1:0] rsp1_tag_q, rsp1_tag_d;

  logic elig0, elig1, gnt0, gnt1, drain0, drain1;

  // Eligibility: a requester may go only if its response slot is free or emptying now.
  always_comb begin
    drain0 = rsp0_valid_q && rsp0_ready;
    drain1 = rsp1_valid_q && rsp1_ready;
    elig0  = req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1  = req1_valid && (!rsp1_valid_q || rsp1_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt0 = elig0;
    gnt1 = elig1 && !elig0;
`else
    if (elig0 && elig1) begin
      gnt0 = last_gnt_q;
      gnt1 = !last_gnt_q;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
`endif
  end

  // Ready is the grant itself, held low while reset is asserted.
  assign req0_ready = rst_n && gnt0;
  assign req1_ready = rst_n && gnt1;

  // Steer the granted operands to the shared ALU; idle drives a harmless add of zeros.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    if (req0_ready) begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
    end else if (req1_ready) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  // Slot and pointer next state: refill wins over drain so back-to-back results have no bubble.
  always_comb begin
    last_gnt_d   = last_gnt_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_f_d     = rsp0_f_q;
    rsp0_tag_d   = rsp0_tag_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_f_d     = rsp1_f_q;
    rsp1_tag_d   = rsp1_tag_q;
    if (req0_ready) last_gnt_d = 1'b0;
    else if (req1_ready) last_gnt_d = 1'b1;
    if (req0_ready) begin
      rsp0_valid_d = 1'b1;
      rsp0_f_d     = alu_f;
      rsp0_tag_d   = req0_tag;
    end else if (drain0) begin
      rsp0_valid_d = 1'b0;
    end
    if (req1_ready) begin
      rsp1_valid_d = 1'b1;
      rsp1_f_d     = alu_f;
      rsp1_tag_d   = req1_tag;
    end else if (drain1) begin
      rsp1_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q   <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp0_f_q     <= 32'd0;
      rsp0_tag_q   <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_f_q     <= 32'd0;
      rsp1_tag_q   <= '0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_f_q     <= rsp0_f_d;
      rsp0_tag_q   <= rsp0_tag_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_f_q     <= rsp1_f_d;
      rsp1_tag_q   <= rsp1_tag_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_f     = rsp0_f_q;
  assign rsp0_tag   = rsp0_tag_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_f     = rsp1_f_q;
  assign rsp1_tag   = rsp1_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural external ALU
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SRA = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_f;
  logic [1:0]  req0_tag, req1_tag, rsp0_tag, rsp1_tag;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_f, rsp1_f;

  logic [31:0] e0, e1;
  logic [33:0] q0[$];
  logic [33:0] q1[$];
  logic [33:0] exp_item;
  logic [31:0] held_f;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_f(rsp0_f), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_f(rsp1_f), .rsp1_tag(rsp1_tag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f)
  );

  // External combinational ALU
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_f = alu_a + alu_b;
      OP_SUB:  alu_f = alu_a - alu_b;
      OP_AND:  alu_f = alu_a & alu_b;
      OP_OR:   alu_f = alu_a | alu_b;
      OP_XOR:  alu_f = alu_a ^ alu_b;
      OP_SLL:  alu_f = alu_a << alu_b[4:0];
      OP_SRL:  alu_f = alu_a >> alu_b[4:0];
      default: alu_f = $unsigned($signed(alu_a) >>> alu_b[4:0]);
    endcase
  end

  // Scoreboard: pop on every response handshake, push on every accepted request
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        n_tests++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL rsp0_unexpected got f=%h tag=%0d, required no response", rsp0_f, rsp0_tag);
        end else begin
          exp_item = q0.pop_front();
          if ({rsp0_f, rsp0_tag} !== exp_item) begin
            n_fail++;
            $display("FAIL rsp0_data got f=%h tag=%0d, required f=%h tag=%0d",
                     rsp0_f, rsp0_tag, exp_item[33:2], exp_item[1:0]);
          end
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        n_tests++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL rsp1_unexpected got f=%h tag=%0d, required no response", rsp1_f, rsp1_tag);
        end else begin
          exp_item = q1.pop_front();
          if ({rsp1_f, rsp1_tag} !== exp_item) begin
            n_fail++;
            $display("FAIL rsp1_data got f=%h tag=%0d, required f=%h tag=%0d",
                     rsp1_f, rsp1_tag, exp_item[33:2], exp_item[1:0]);
          end
        end
      end
      if (req0_valid && req0_ready) q0.push_back({e0, req0_tag});
      if (req1_valid && req1_ready) q1.push_back({e1, req1_tag});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %h, required %h", name, act, req);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_op = OP_ADD; req0_a = 0; req0_b = 0; req0_tag = 0; e0 = 0;
    req1_valid = 0; req1_op = OP_ADD; req1_a = 0; req1_b = 0; req1_tag = 0; e1 = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic rst_pulse();
    idle_inputs();
    rst_n = 0;
    nxt();
    nxt();
    rst_n = 1;
  endtask

  task automatic set0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] tag, input logic [31:0] ef);
    req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag; e0 = ef;
  endtask

  task automatic set1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] tag, input logic [31:0] ef);
    req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag; e1 = ef;
  endtask

  logic [31:0] all_ops_exp [8];
  logic [1:0] gnt_seq [4];

  initial begin
    all_ops_exp = '{32'h800000F4, 32'h800000EC, 32'h00000000, 32'h800000F4,
                    32'h800000F4, 32'h00000F00, 32'h0800000F, 32'hF800000F};
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt_seq = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    gnt_seq = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    // Reset state, with both requesters pushing
    idle_inputs();
    rst_n = 0;
    req0_valid = 1;
    req1_valid = 1;
    #2;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("rst_rsp0_f", rsp0_f, 32'd0);
    chk("rst_rsp_tag", {28'd0, rsp0_tag, rsp1_tag}, 32'd0);
    req0_valid = 0;
    req1_valid = 0;
    nxt();
    nxt();
    rst_n = 1;

    // Single add right after reset release, latency one
    set0(OP_ADD, 32'd5, 32'd7, 2'd1, 32'd12);
    @(negedge clk);
    chk("first_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("first_alu_a", alu_a, 32'd5);
    nxt();
    req0_valid = 0;
    @(negedge clk);
    chk("first_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("first_rsp0_f", rsp0_f, 32'd12);
    chk("first_rsp0_tag", {30'd0, rsp0_tag}, 32'd1);
    nxt();
    @(negedge clk);
    chk("first_rsp0_cleared", {31'd0, rsp0_valid}, 32'd0);
    chk("idle_alu_op", {29'd0, alu_op}, {29'd0, OP_ADD});
    nxt();

    // Contention from a fresh reset
    rst_pulse();
    set0(OP_SUB, 32'd10, 32'd3, 2'd2, 32'd7);
    set1(OP_SLL, 32'd1, 32'd4, 2'd3, 32'd16);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("contend_req0_ready_%0d", i), {31'd0, req0_ready}, {31'd0, gnt_seq[i] == 2'd0});
      chk($sformatf("contend_req1_ready_%0d", i), {31'd0, req1_ready}, {31'd0, gnt_seq[i] == 2'd1});
      nxt();
    end
    req0_valid = 0;
    req1_valid = 0;
    nxt();
    nxt();

    // Slot 1 blocked: requester 0 keeps flowing, slot 1 held
    rsp1_ready = 0;
    set1(OP_ADD, 32'd3, 32'd4, 2'd1, 32'd7);
    @(negedge clk);
    chk("blk_fill_req1_ready", {31'd0, req1_ready}, 32'd1);
    nxt();
    set0(OP_XOR, 32'hF0, 32'hFF, 2'd0, 32'h0F);
    set1(OP_OR, 32'd1, 32'd2, 2'd2, 32'd3);
    held_f = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("blk_req1_ready_%0d", i), {31'd0, req1_ready}, 32'd0);
      chk($sformatf("blk_req0_ready_%0d", i), {31'd0, req0_ready}, 32'd1);
      chk($sformatf("blk_rsp1_f_%0d", i), rsp1_f, held_f);
      chk($sformatf("blk_rsp1_valid_%0d", i), {31'd0, rsp1_valid}, 32'd1);
      nxt();
    end
    req0_valid = 0;
    rsp1_ready = 1;
    @(negedge clk);
    chk("blk_release_req1_ready", {31'd0, req1_ready}, 32'd1);
    nxt();
    req1_valid = 0;
    nxt();
    nxt();

    // Drain and refill slot 0 in the same cycle
    rsp0_ready = 0;
    set0(OP_OR, 32'h10, 32'h01, 2'd1, 32'h11);
    nxt();
    req0_valid = 0;
    nxt();
    rsp0_ready = 1;
    set0(OP_SRA, 32'h80000000, 32'd4, 2'd2, 32'hF8000000);
    @(negedge clk);
    chk("refill_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("refill_old_f", rsp0_f, 32'h11);
    nxt();
    req0_valid = 0;
    @(negedge clk);
    chk("refill_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("refill_rsp0_f", rsp0_f, 32'hF8000000);
    nxt();
    nxt();

    // All eight opcodes back to back on requester 0
    for (int i = 0; i < 8; i++) begin
      set0(3'(i), 32'h800000F0, 32'd4, 2'(i), all_ops_exp[i]);
      @(negedge clk);
      chk($sformatf("ops_req0_ready_%0d", i), {31'd0, req0_ready}, 32'd1);
      nxt();
    end
    req0_valid = 0;
    nxt();
    nxt();

    // Asynchronous reset with both slots full
    rsp0_ready = 0;
    rsp1_ready = 0;
    set0(OP_ADD, 32'd1, 32'd1, 2'd1, 32'd2);
    nxt();
    req0_valid = 0;
    set1(OP_ADD, 32'd2, 32'd2, 2'd2, 32'd4);
    nxt();
    req1_valid = 0;
    chk("prerst_both_full", {30'd0, rsp0_valid, rsp1_valid}, 32'd3);
    rst_n = 0;
    #1;
    chk("async_rst_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    nxt();
    rst_n = 1;
    rsp0_ready = 1;
    rsp1_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_no_stale_%0d", i), {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      nxt();
    end
    set1(OP_SUB, 32'd9, 32'd4, 2'd3, 32'd5);
    @(negedge clk);
    chk("postrst_req1_ready", {31'd0, req1_ready}, 32'd1);
    nxt();
    req1_valid = 0;
    nxt();
    nxt();

    @(negedge clk);
    chk("sb_q0_empty", q0.size(), 32'd0);
    chk("sb_q1_empty", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
